spi_slave_param: RTL

Parametrised SPI slave: next generation of the fixed 32-bit, mode-0 slave. It adds configurable word width, all four SPI modes, selectable bit order, input synchronisers, buffered valid/ready data paths, and explicit abort, underrun and overrun reporting. It sits between an external SPI master (pins SCLK/CS/MOSI/MISO) and an on-chip register or FIFO client in the `clk` domain.

---
 rtl/spi_slave_param.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: synchronised pins, all four SPI modes, selectable bit order,
// one-entry transmit holding register and valid/ready receive register with error pulses.
module spi_slave_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0,
  parameter bit          LSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  frame_abort,
  output logic                  tx_underrun,
  output logic                  rx_overrun
);

  localparam int unsigned     CNT_W     = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state, state_next;
  logic [2:0]            sclk_sync, cs_sync;
  logic [1:0]            mosi_sync;
  logic [DATA_WIDTH-1:0] hold_data, tx_shift, rx_shift, rx_next, tx_word;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  lead_edge, trail_edge, sample_edge, shift_edge;
  logic                  cs_fall, cs_low, mosi_bit;
  logic                  load_c, sample_c, shift_c, complete_c, abort_c;

  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] v);
    return LSB_FIRST ? {1'b0, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], 1'b0};
  endfunction

  // Two-flop synchronisers; the third SCLK/CS flop feeds edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= {3{CPOL}};
      cs_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], SCLK};
      cs_sync   <= {cs_sync[1:0], CS};
      mosi_sync <= {mosi_sync[0], MOSI};
    end
  end

  assign lead_edge   = (sclk_sync[2] == CPOL) && (sclk_sync[1] != CPOL);
  assign trail_edge  = (sclk_sync[2] != CPOL) && (sclk_sync[1] == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_sync[2] && !cs_sync[1];
  assign cs_low      = !cs_sync[1];
  assign mosi_bit    = mosi_sync[1];
  assign tx_word     = tx_ready ? '0 : hold_data;
  assign rx_next     = LSB_FIRST ? {mosi_bit, rx_shift[DATA_WIDTH-1:1]}
                                 : {rx_shift[DATA_WIDTH-2:0], mosi_bit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Completion wins over a simultaneous CS rise; in CPHA=0 the shift edge before
  // the first sample of a word is skipped so a reloaded first bit stays on MISO.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    sample_c   = 1'b0;
    shift_c    = 1'b0;
    complete_c = 1'b0;
    abort_c    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          load_c     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (sample_edge && bit_cnt == CNT_FINAL) begin
          sample_c   = 1'b1;
          complete_c = 1'b1;
          state_next = DONE;
        end else if (!cs_low) begin
          abort_c    = 1'b1;
          state_next = IDLE;
        end else if (sample_edge) begin
          sample_c = 1'b1;
        end else if (shift_edge && (CPHA || bit_cnt != '0)) begin
          shift_c = 1'b1;
        end
      end
      DONE: begin
        if (cs_low) begin
          load_c     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: holding register, shifters, receive register and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data   <= '0;
      tx_ready    <= 1'b1;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      MISO        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      frame_abort <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      frame_abort <= abort_c;
      tx_underrun <= load_c && tx_ready;
      rx_overrun  <= complete_c && rx_valid && !rx_ready;
      busy        <= (state_next != IDLE);
      miso_oe     <= !cs_sync[0];

      if (load_c) tx_ready <= 1'b1;
      if (tx_valid && tx_ready) begin
        hold_data <= tx_data;
        tx_ready  <= 1'b0;
      end

      if (load_c) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        if (CPHA) begin
          tx_shift <= tx_word;
        end else begin
          MISO     <= out_bit(tx_word);
          tx_shift <= advance(tx_word);
        end
      end else begin
        if (sample_c) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + CNT_W'(1);
        end
        if (shift_c) begin
          MISO     <= out_bit(tx_shift);
          tx_shift <= advance(tx_shift);
        end
      end

      if (complete_c) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
